bake_m_frame_tx: RTL and testbench

- Transmit-side frame generator for the QPSK link. Produces 2-bit symbols for the mapper.
- Each frame is a 13-symbol Barker preamble followed by m-sequence payload symbols.
- Frame length and symbol pacing match the receive-side Barker detector/counter: 1027 symbols per frame, one symbol per 2 clk_fs cycles.

---
 rtl/bake_m_frame_tx.sv | 122 ++++++++++++
 tb/tb_bake_m_frame_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bake_m_frame_tx.sv
// bake_m_frame_tx: QPSK transmit frame generator.
// Each frame is a 13-chip Barker preamble followed by FRAME_LEN-13 payload
// symbols drawn from a 10-bit x^10+x^7+1 m-sequence, one symbol per SPS clocks.
// Optional macro BAKE_TX_AUTO_REPEAT_EN: start held high on the last-symbol
// edge chains straight into the next frame with no idle gap.
module bake_m_frame_tx #(
  parameter int          FRAME_LEN = 1027,
  parameter int          SPS       = 2,
  parameter logic [9:0]  SEED      = 10'h3FF
) (
  input  logic        clk_fs,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:0]  bit_tx,
  output logic        sym_en,
  output logic        busy,
  output logic        frame_done,
  output logic [10:0] sym_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;

  localparam int          DW       = $clog2(SPS);
  localparam logic [12:0] BARKER   = 13'b1010110011111; // bit i = chip i
  localparam logic [DW-1:0] DIV_LAST = DW'(SPS - 1);
  localparam logic [10:0] LAST_SYM = 11'(FRAME_LEN - 1);
  localparam logic [10:0] LAST_PRE = 11'd12;

  state_t          state;
  logic [DW-1:0]   div;
  logic [9:0]      lfsr;
  logic [9:0]      lfsr_s1;
  logic [9:0]      lfsr_s2;
  logic [1:0]      pay_sym;
  logic [10:0]     sym_nxt;
  logic [3:0]      bidx;
  logic            chip;
  logic            chip0;
  logic            sym_last;
  logic            frame_last;

  // Two LFSR steps looked ahead so a whole payload symbol loads in one edge
  always_comb begin
    lfsr_s1    = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    lfsr_s2    = {lfsr_s1[8:0], lfsr_s1[9] ^ lfsr_s1[6]};
    pay_sym    = {lfsr[9], lfsr_s1[9]};
    sym_nxt    = sym_cnt + 11'd1;
    bidx       = sym_nxt[3:0];
    chip       = BARKER[bidx];
    chip0      = BARKER[0];
    sym_last   = (div == DIV_LAST);
    frame_last = sym_last && (sym_cnt == LAST_SYM);
  end

  // Frame sequencer: divider, symbol counter, preamble/payload selection
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      lfsr       <= SEED;
      bit_tx     <= '0;
      sym_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sym_cnt    <= '0;
    end else begin
      sym_en     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRE;
            busy    <= 1'b1;
            sym_cnt <= '0;
            div     <= '0;
            lfsr    <= SEED;
            bit_tx  <= {chip0, chip0};
            sym_en  <= 1'b1;
          end
        end
        PRE, PAY: begin
          if (frame_last) begin
            frame_done <= 1'b1;
            sym_cnt    <= '0;
            div        <= '0;
`ifdef BAKE_TX_AUTO_REPEAT_EN
            if (start) begin
              state  <= PRE;
              lfsr   <= SEED;
              bit_tx <= {chip0, chip0};
              sym_en <= 1'b1;
            end else begin
              state  <= IDLE;
              busy   <= 1'b0;
              bit_tx <= '0;
            end
`else
            state  <= IDLE;
            busy   <= 1'b0;
            bit_tx <= '0;
`endif
          end else if (sym_last) begin
            div     <= '0;
            sym_cnt <= sym_nxt;
            sym_en  <= 1'b1;
            if (state == PRE && sym_cnt != LAST_PRE) begin
              bit_tx <= {chip, chip};
            end else begin
              state  <= PAY;
              bit_tx <= pay_sym;
              lfsr   <= lfsr_s2;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bake_m_frame_tx.sv
// Testbench for bake_m_frame_tx: scoreboard of expected symbols per frame,
// popped on every sym_en; directed steps cover reset, start-while-busy,
// mid-frame reset abort and start held across the frame boundary.
module tb_bake_m_frame_tx;

  localparam int FRAME_LEN = 1027;
  localparam int SPS       = 2;
  localparam int PAY_LEN   = FRAME_LEN - 13;
  localparam int NBITS     = 2 * PAY_LEN + 10;

  typedef struct {
    logic [10:0] idx;
    logic [1:0]  sym;
  } exp_t;

  logic        clk_fs = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  bit_tx;
  logic        sym_en;
  logic        busy;
  logic        frame_done;
  logic [10:0] sym_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_en = 0;
  int t0 = 0;
  int done_cnt = 0;
  logic [1:0] held = '0;
  exp_t exp_q[$];
  logic mseq [NBITS];
  int barker [13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};

  bake_m_frame_tx #(.FRAME_LEN(FRAME_LEN), .SPS(SPS), .SEED(10'h3FF)) dut (
    .clk_fs     (clk_fs),
    .rst_n      (rst_n),
    .start      (start),
    .bit_tx     (bit_tx),
    .sym_en     (sym_en),
    .busy       (busy),
    .frame_done (frame_done),
    .sym_cnt    (sym_cnt)
  );

  always #50 clk_fs = ~clk_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_fs);
    #1;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      e.idx = 11'(i);
      e.sym = {barker[i][0], barker[i][0]};
      exp_q.push_back(e);
    end
    for (int j = 0; j < PAY_LEN; j++) begin
      e.idx = 11'(13 + j);
      e.sym = {mseq[2*j], mseq[2*j+1]};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      step();
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic wait_sym(input int idx, input int max_cyc);
    bit seen;
    seen = 0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      step();
      if (sym_en && sym_cnt == 11'(idx)) seen = 1;
    end
    if (!seen) check("sym_timeout", 0, 1);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk_fs) begin
    cyc++;
    if (rst_n) begin
      if (frame_done) begin
        done_cnt++;
        check("frame_len", cyc - t0, FRAME_LEN * SPS);
`ifdef BAKE_TX_AUTO_REPEAT_EN
        if (!sym_en) begin
          check("done_busy", busy, 0);
          check("done_bit_tx", bit_tx, 0);
        end
`else
        check("done_busy", busy, 0);
        check("done_bit_tx", bit_tx, 0);
`endif
        check("done_sym_cnt", sym_cnt, 0);
      end
      if (sym_en) begin
        if (sym_cnt != 0) check("sym_gap", cyc - last_en, SPS);
        else t0 = cyc;
        last_en = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_sym", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sym_idx", sym_cnt, e.idx);
          check("bit_tx", bit_tx, e.sym);
        end
        held = bit_tx;
        if (sym_cnt == 11'd13) check("lfsr_after_13", dut.lfsr, 10'h3FC);
      end else if (busy) begin
        check("bit_hold", bit_tx, held);
      end
    end
  end

  initial begin
    int d0;
    int c0;
    // Golden m-sequence via its linear recurrence o[k+10] = o[k] ^ o[k+3]
    for (int k = 0; k < 10; k++) mseq[k] = 1'b1;
    for (int k = 10; k < NBITS; k++) mseq[k] = mseq[k-10] ^ mseq[k-7];

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) step();
    check("rst_bit_tx", bit_tx, 0);
    check("rst_sym_en", sym_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Frame 1: single start pulse, full frame
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("sym_en_after_start", sym_en, 1);
    wait_done(3000);
    step();
    check("idle_busy", busy, 0);
    check("idle_sym_en", sym_en, 0);

    // Frame 2: start pulse mid-frame is ignored and not queued
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_sym(500, 3000);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3000);
    repeat (5) step();
    check("no_queued_start", busy, 0);
    check("queue_drained_2", exp_q.size(), 0);

    // Frame 3: reset at symbol 700 aborts without frame_done
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_sym(700, 3000);
    #10 rst_n = 1'b0;
    #1;
    check("abort_bit_tx", bit_tx, 0);
    check("abort_sym_en", sym_en, 0);
    check("abort_busy", busy, 0);
    check("abort_sym_cnt", sym_cnt, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (4) step();
    check("abort_no_done", done_cnt, d0);
    rst_n = 1'b1;
    repeat (2) step();

    // Frame 4: full frame after reset release
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3000);
    repeat (2) step();

    // Frames 5/6: start held high across the frame boundary
    push_frame();
    push_frame();
    start = 1'b1;
    step();
    c0 = cyc;
    wait_done(3000);
`ifdef BAKE_TX_AUTO_REPEAT_EN
    check("repeat_busy", busy, 1);
    check("repeat_sym_en", sym_en, 1);
    start = 1'b0;
`else
    check("held_idle_gap", busy, 0);
    step();
    start = 1'b0;
    check("held_restart_busy", busy, 1);
    check("held_restart_sym_en", sym_en, 1);
`endif
    wait_done(3000);
`ifdef BAKE_TX_AUTO_REPEAT_EN
    check("two_frame_len", cyc - c0, 2 * FRAME_LEN * SPS);
`endif
    repeat (3) step();
    check("queue_drained_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
